register_cmd_scheduler: RTL and testbench

Round-robin scheduler that converts level request lines from up to N_REQ sources (push-buttons, control strobes) into single register commands for the register datapath. Each source's rising edge is captured as a pending request. The scheduler grants one pending request at a time and presents it as an opcode on a valid/ready handshake. It sits between the input conditioning logic and the register datapath, so the datapath executes exactly one operation per request edge.

---
 rtl/register_cmd_scheduler_pkg.sv | 17 +
 rtl/edge_pulse_sync.sv | 24 ++
 rtl/register_cmd_scheduler.sv | 103 ++++++++++
 tb/tb_register_cmd_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_cmd_scheduler_pkg.sv
// Shared types and constants for the register command scheduler and datapath.
// The datapath decodes cmd_op using the CMD_* indices.
package register_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } sched_state_e;

  localparam int unsigned NReqDefault = 4;

  localparam int unsigned CMD_LOAD = 0;
  localparam int unsigned CMD_INC  = 1;
  localparam int unsigned CMD_DEC  = 2;
  localparam int unsigned CMD_CLR  = 3;

endpackage

// File: rtl/edge_pulse_sync.sv
// One-bit rising-edge detector built from two sampling flops.
// The flops clear to zero, so a line held high through reset yields one pulse afterwards.
module edge_pulse_sync (
  input  logic clk,
  input  logic synch_reset,
  input  logic d_i,
  output logic pulse_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign pulse_o = s1_q & ~s2_q;

endmodule

// File: rtl/register_cmd_scheduler.sv
// Round-robin scheduler turning request-line edges into single register commands
// presented on a valid/ready handshake.
module register_cmd_scheduler
  import register_pkg::*;
#(
  parameter  int unsigned N_REQ = NReqDefault,
  localparam int unsigned OP_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             synch_reset,
  input  logic [N_REQ-1:0] req_in,
  output logic             cmd_valid,
  output logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_ready,
  output logic [N_REQ-1:0] pending,
  output logic             overrun
);

  // First set bit at or above ptr, wrapping; the power-of-two N_REQ makes the add wrap.
  function automatic logic [OP_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [OP_W-1:0]  ptr);
    logic [OP_W-1:0] idx;
    rr_pick = ptr;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = ptr + OP_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic [N_REQ-1:0] edge_det;

  for (genvar i = 0; i < N_REQ; i++) begin : g_edge
    edge_pulse_sync u_edge (
      .clk        (clk),
      .synch_reset(synch_reset),
      .d_i        (req_in[i]),
      .pulse_o    (edge_det[i])
    );
  end

  sched_state_e     state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [OP_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] clr_mask;
  logic             overrun_q, overrun_d;
  logic             accept;

  assign accept = (state_q == StIssue) & cmd_ready;

  // A new edge on the source being accepted re-arms it instead of counting as overrun.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[op_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | edge_det;
    overrun_d = |(edge_det & pending_q & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          op_d    = rr_pick(pending_q, ptr_q);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          ptr_d   = op_q + OP_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_valid = (state_q == StIssue);
    cmd_op    = op_q;
    pending   = pending_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_register_cmd_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// each cycle compared against a behavioural model of the scheduling rules.
module tb_register_cmd_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         synch_reset = 1'b1;
  logic [N-1:0] req_in = '0;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [N-1:0] pending;
  logic         overrun;

  int checks = 0;
  int failures = 0;

  // Model state: last two samples of req_in, pending set, command slot, rotation pointer.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_pend = '0;
  bit           m_valid = 0, m_ovr = 0;
  int           m_op = 0, m_ptr = 0;

  register_cmd_scheduler #(.N_REQ(N)) dut (
    .clk        (clk),
    .synch_reset(synch_reset),
    .req_in     (req_in),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .pending    (pending),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: predict from the rules, then compare all outputs after the edge.
  task automatic tick();
    logic [N-1:0] edg, clr, n_pend;
    bit           acc, n_valid, n_ovr, found;
    int           n_op, n_ptr, idx;
    if (synch_reset) begin
      n_pend = '0; n_valid = 0; n_ovr = 0; n_op = 0; n_ptr = 0;
      edg = '0;
    end else begin
      edg    = m_s1 & ~m_s2;
      acc    = m_valid && cmd_ready;
      clr    = acc ? (N'(1) << m_op) : '0;
      n_ovr  = |(edg & m_pend & ~clr);
      n_pend = (m_pend & ~clr) | edg;
      n_valid = m_valid; n_op = m_op; n_ptr = m_ptr;
      if (m_valid) begin
        if (acc) begin
          n_valid = 0;
          n_ptr   = (m_op + 1) % N;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && m_pend[idx]) begin
            found = 1; n_op = idx; n_valid = 1;
          end
        end
      end
    end
    if (synch_reset) begin
      m_s1 = '0; m_s2 = '0;
    end else begin
      m_s2 = m_s1; m_s1 = req_in;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_valid = n_valid; m_ovr = n_ovr; m_op = n_op; m_ptr = n_ptr;
    chk("model_valid", int'(cmd_valid), int'(m_valid));
    chk("model_op", int'(cmd_op), m_op);
    chk("model_pending", int'(pending), int'(m_pend));
    chk("model_overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic do_reset();
    synch_reset = 1'b1;
    tick();
    tick();
    synch_reset = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !cmd_valid; i++) tick();
    chk("wait_valid_timeout", int'(cmd_valid), 1);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    req_in = v;
    tick();
    req_in = '0;
  endtask

  initial begin
    int q[$];
    int cnt;
    bit prev_valid;

    // Reset state
    cmd_ready = 1'b1;
    do_reset();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_op", int'(cmd_op), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Single pulse on source 2
    pulse(4'b0100);
    tick();
    chk("s2_pending", int'(pending), 4'b0100);
    tick();
    chk("s2_valid", int'(cmd_valid), 1);
    chk("s2_op", int'(cmd_op), 2);
    tick();
    chk("s2_accepted_pending", int'(pending), 0);
    chk("s2_accepted_valid", int'(cmd_valid), 0);

    // All four together: rotate 0..3 with an idle cycle between commands
    do_reset();
    cmd_ready = 1'b1;
    req_in = 4'b1111;
    prev_valid = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (prev_valid) chk("rr_idle_gap", int'(cmd_valid), 0);
      if (cmd_valid) q.push_back(int'(cmd_op));
      prev_valid = cmd_valid;
    end
    chk("rr_count", q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++) chk("rr_order", q[i], i);
    req_in = '0;
    tick();
    tick();
    req_in = 4'b1111;
    wait_valid(8);
    chk("rr_wrap_op", int'(cmd_op), 0);
    req_in = '0;

    // Stall with op 1 while source 3 arrives
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0010);
    wait_valid(8);
    chk("stall_op_first", int'(cmd_op), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req_in = 4'b1000;
      if (i == 2) req_in = '0;
      tick();
      chk("stall_valid", int'(cmd_valid), 1);
      chk("stall_op", int'(cmd_op), 1);
    end
    chk("stall_pending3", int'(pending[3]), 1);
    cmd_ready = 1'b1;
    tick();
    wait_valid(8);
    chk("stall_next_op", int'(cmd_op), 3);

    // Second edge on source 0 while pending: one overrun, one grant
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0001);
    wait_valid(8);
    chk("ovr_op", int'(cmd_op), 0);
    pulse(4'b0001);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (overrun) cnt++;
    end
    chk("ovr_pulse_count", cnt, 1);
    cmd_ready = 1'b1;
    cnt = cmd_valid ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid && cmd_op == 2'd0) cnt++;
    end
    chk("ovr_grant_count", cnt, 1);

    // Edge on source 1 coincident with acceptance of command 1
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0010);
    wait_valid(8);
    tick();
    tick();
    req_in = 4'b0010;
    tick();
    req_in = '0;
    cmd_ready = 1'b1;
    tick();
    chk("coinc_pending1", int'(pending[1]), 1);
    chk("coinc_overrun", int'(overrun), 0);
    chk("coinc_valid", int'(cmd_valid), 0);
    wait_valid(8);
    chk("coinc_second_op", int'(cmd_op), 1);

    // Line held through reset gives exactly one command
    req_in = 4'b0100;
    do_reset();
    cmd_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmd_valid) begin
        cnt++;
        chk("held_op", int'(cmd_op), 2);
      end
    end
    chk("held_count", cnt, 1);

    // Reset while a command is issuing
    req_in = '0;
    cmd_ready = 1'b0;
    tick();
    tick();
    pulse(4'b0001);
    wait_valid(8);
    synch_reset = 1'b1;
    tick();
    synch_reset = 1'b0;
    chk("midrst_valid", int'(cmd_valid), 0);
    chk("midrst_pending", int'(pending), 0);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) req_in[b] = ~req_in[b];
      cmd_ready   = ($urandom_range(0, 2) != 0);
      synch_reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    synch_reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
